// File: rtl/ept_uc_pkg.sv
// Shared constants for the uc_out output combiner.
// Also holds the pointer-width helper used by the arbiter and its picker.
package ept_uc_pkg;

    localparam int UC_WORD_W  = 30;
    localparam int UC_MODE_OR = 0;
    localparam int UC_MODE_RR = 1;

    // A one-channel build still needs a one-bit pointer.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ept_rr_pick.sv
// Rotating priority encoder: the first set request after ptr wins.
// Search order is ptr+1 .. ptr+N, modulo N.
module ept_rr_pick
    import ept_uc_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = ptr_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [PW-1:0] idx,
    output logic          any
);

    always_comb begin
        logic found;
        int   pos;
        onehot = '0;
        idx    = ptr;
        found  = 1'b0;
        pos    = 0;
        for (int k = 1; k <= N; k++) begin
            pos = (int'(ptr) + k) % N;
            if (!found && req[pos]) begin
                found       = 1'b1;
                onehot[pos] = 1'b1;
                idx         = PW'(pos);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/ept_uc_out_arbiter.sv
// Registered valid/ready combiner for N user output buses onto one uc_out word,
// either as a collision-flagged OR of all requesters or as a round-robin arbiter.
module ept_uc_out_arbiter
    import ept_uc_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = UC_WORD_W,
    parameter int MODE = UC_MODE_RR
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N*W-1:0] uc_out_m,
    input  logic [N-1:0]   req_m,
    output logic [N-1:0]   gnt_m,
    output logic [W-1:0]   uc_out,
    output logic           uc_out_valid,
    input  logic           uc_out_ready,
    output logic           collision,
    input  logic           collision_clr
);

    localparam int PW = ptr_width(N);

    logic [PW-1:0] ptr_reg;
    logic [PW-1:0] ptr_next;
    logic [W-1:0]  uc_out_reg;
    logic          valid_reg;
    logic          collision_reg;
    logic [N-1:0]  ch_sel;
    logic          req_any;
    logic          load;
    logic          collision_set;
    logic [W-1:0]  masked [N];
    logic [W-1:0]  word_next;

    generate
        if (MODE == UC_MODE_RR) begin : g_rr
            logic [N-1:0]  pick_onehot;
            logic [PW-1:0] pick_idx;
            logic          pick_any;

            ept_rr_pick #(.N(N), .PW(PW)) u_pick (
                .req    (req_m),
                .ptr    (ptr_reg),
                .onehot (pick_onehot),
                .idx    (pick_idx),
                .any    (pick_any)
            );

            assign ch_sel   = pick_onehot;
            assign req_any  = pick_any;
            assign ptr_next = pick_idx;
        end else begin : g_or
            assign ch_sel   = req_m;
            assign req_any  = |req_m;
            assign ptr_next = ptr_reg;
        end
    endgenerate

    // A new word may be captured whenever the output slot is empty or being taken.
    assign load  = reset_n & (~valid_reg | uc_out_ready) & req_any;
    assign gnt_m = {N{load}} & ch_sel;

    // Only selected channels reach the reduction, so idle slices can carry anything.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_mask
            assign masked[gi] = ch_sel[gi] ? uc_out_m[gi*W +: W] : '0;
        end
    endgenerate

    always_comb begin
        word_next = '0;
        for (int i = 0; i < N; i++) begin
            word_next = word_next | masked[i];
        end
    end

    assign collision_set = (MODE == UC_MODE_OR) && load && ($countones(req_m) > 1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            uc_out_reg    <= '0;
            valid_reg     <= 1'b0;
            ptr_reg       <= PW'(N - 1);
            collision_reg <= 1'b0;
        end else begin
            if (load) begin
                uc_out_reg <= word_next;
                valid_reg  <= 1'b1;
                ptr_reg    <= ptr_next;
            end else if (uc_out_ready) begin
                valid_reg  <= 1'b0;
            end
            // A fresh collision outranks a clear in the same cycle.
            if (collision_set) begin
                collision_reg <= 1'b1;
            end else if (collision_clr) begin
                collision_reg <= 1'b0;
            end
        end
    end

    assign uc_out       = uc_out_reg;
    assign uc_out_valid = valid_reg;
    assign collision    = collision_reg;

endmodule

// File: tb/tb_ept_uc_out_arbiter.sv
// Scoreboard bench: one OR-mode and one round-robin instance share the same random
// and directed stimulus; a behavioural model queues expected words, a monitor pops them.
module tb_ept_uc_out_arbiter;

    localparam int N = 4;
    localparam int W = 30;

    logic           clk;
    logic           reset_n;
    logic [N*W-1:0] uc_out_m;
    logic [N-1:0]   req_m;
    logic           uc_out_ready;
    logic           collision_clr;

    logic [N-1:0] dut_gnt [2];
    logic [W-1:0] dut_out [2];
    logic         dut_vld [2];
    logic         dut_col [2];

    int vectors;
    int miscompares;

    // index 0 = OR mode instance, index 1 = round-robin instance
    ept_uc_out_arbiter #(.N(N), .W(W), .MODE(0)) u_or (
        .clk           (clk),
        .reset_n       (reset_n),
        .uc_out_m      (uc_out_m),
        .req_m         (req_m),
        .gnt_m         (dut_gnt[0]),
        .uc_out        (dut_out[0]),
        .uc_out_valid  (dut_vld[0]),
        .uc_out_ready  (uc_out_ready),
        .collision     (dut_col[0]),
        .collision_clr (collision_clr)
    );

    ept_uc_out_arbiter #(.N(N), .W(W), .MODE(1)) u_rr (
        .clk           (clk),
        .reset_n       (reset_n),
        .uc_out_m      (uc_out_m),
        .req_m         (req_m),
        .gnt_m         (dut_gnt[1]),
        .uc_out        (dut_out[1]),
        .uc_out_valid  (dut_vld[1]),
        .uc_out_ready  (uc_out_ready),
        .collision     (dut_col[1]),
        .collision_clr (collision_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic         m_valid [2];
    logic [W-1:0] m_last  [2];
    logic         m_col   [2];
    int           m_ptr;
    logic [W-1:0] q_or[$];
    logic [W-1:0] q_rr[$];

    function automatic string mname(input int m);
        return (m == 0) ? "or" : "rr";
    endfunction

    function automatic logic [N-1:0] exp_grant(input int m);
        logic [N-1:0] g;
        g = '0;
        if (reset_n && !(m_valid[m] && !uc_out_ready) && req_m != '0) begin
            if (m == 0) begin
                g = req_m;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (g == '0 && req_m[c]) g[c] = 1'b1;
                end
            end
        end
        return g;
    endfunction

    function automatic logic [W-1:0] exp_word(input logic [N-1:0] g);
        logic [W-1:0] w;
        w = '0;
        for (int c = 0; c < N; c++) begin
            if (g[c]) w = w | uc_out_m[c*W +: W];
        end
        return w;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            m_valid[m] = 1'b0;
            m_last[m]  = '0;
            m_col[m]   = 1'b0;
        end
        m_ptr = N - 1;
    end

    // Model update at each active edge; inputs are stable here (driven at edge+2).
    always @(posedge clk) begin : model
        logic [N-1:0] g [2];
        for (int m = 0; m < 2; m++) g[m] = exp_grant(m);
        for (int m = 0; m < 2; m++) begin
            if (!reset_n) begin
                m_valid[m] = 1'b0;
                m_last[m]  = '0;
                m_col[m]   = 1'b0;
            end else if (g[m] != '0) begin
                m_valid[m] = 1'b1;
                m_last[m]  = exp_word(g[m]);
                if (m == 0) q_or.push_back(m_last[m]);
                else        q_rr.push_back(m_last[m]);
                if (m == 0 && $countones(g[m]) > 1) m_col[m] = 1'b1;
                else if (collision_clr)            m_col[m] = 1'b0;
                if (m == 1) begin
                    for (int c = 0; c < N; c++) if (g[m][c]) m_ptr = c;
                end
            end else begin
                if (uc_out_ready)  m_valid[m] = 1'b0;
                if (collision_clr) m_col[m]   = 1'b0;
            end
        end
        if (!reset_n) begin
            m_ptr = N - 1;
            q_or.delete();
            q_rr.delete();
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        int           sz;
        logic [W-1:0] fr;
        for (int m = 0; m < 2; m++) begin
            sz = (m == 0) ? q_or.size() : q_rr.size();
            fr = '0;
            if (sz != 0) fr = (m == 0) ? q_or[0] : q_rr[0];
            chk({mname(m), " valid"}, 64'(dut_vld[m]), 64'(sz != 0));
            if (dut_vld[m] && sz != 0) chk({mname(m), " word"}, 64'(dut_out[m]), 64'(fr));
            chk({mname(m), " held"}, 64'(dut_out[m]), 64'(m_last[m]));
            chk({mname(m), " collision"}, 64'(dut_col[m]), 64'(m_col[m]));
            if (dut_vld[m] && uc_out_ready && sz != 0) begin
                $display("txn %s word=%h", mname(m), fr);
                if (m == 0) void'(q_or.pop_front());
                else        void'(q_rr.pop_front());
            end
        end
    end

    // ---------------- driver ----------------
    logic [N-1:0] s_gnt [2];
    logic [W-1:0] s_out [2];
    logic         s_vld [2];
    logic         s_col [2];

    task automatic set_slice(input int ch, input logic [W-1:0] v);
        uc_out_m[ch*W +: W] = v;
    endtask

    // Drive one cycle of inputs, check the combinational grants, then advance.
    task automatic step(input logic rn, input logic [N-1:0] rq, input logic rdy, input logic clr);
        reset_n       = rn;
        req_m         = rq;
        uc_out_ready  = rdy;
        collision_clr = clr;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk({mname(m), " gnt"}, 64'(dut_gnt[m]), 64'(exp_grant(m)));
            s_gnt[m] = dut_gnt[m];
            s_out[m] = dut_out[m];
            s_vld[m] = dut_vld[m];
            s_col[m] = dut_col[m];
        end
        @(posedge clk);
        #2;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        uc_out_m    = '0;
        set_slice(0, 30'h1);
        set_slice(1, 30'h2);
        set_slice(2, 30'h3);
        set_slice(3, 30'h4);

        // Reset with all channels requesting: no grants, cleared outputs.
        for (int i = 0; i < 3; i++) step(1'b0, 4'b1111, 1'b1, 1'b0);
        chk("rst gnt", 64'(s_gnt[1]), 64'd0);
        chk("rst out", 64'(s_out[1]), 64'd0);
        chk("rst vld", 64'(s_vld[1]), 64'd0);

        // Rotation 0,1,2,3,0.
        step(1'b1, 4'b1111, 1'b1, 1'b0); chk("rot g0", 64'(s_gnt[1]), 64'b0001);
        step(1'b1, 4'b1111, 1'b1, 1'b0); chk("rot g1", 64'(s_gnt[1]), 64'b0010);
        chk("rot out1", 64'(s_out[1]), 64'h1);
        step(1'b1, 4'b1111, 1'b1, 1'b0); chk("rot g2", 64'(s_gnt[1]), 64'b0100);
        step(1'b1, 4'b1111, 1'b1, 1'b0); chk("rot g3", 64'(s_gnt[1]), 64'b1000);
        step(1'b1, 4'b1111, 1'b1, 1'b0); chk("rot g0b", 64'(s_gnt[1]), 64'b0001);
        chk("rot out4", 64'(s_out[1]), 64'h4);

        // Back-pressure on a held 0x2A word (ptr is 0 here).
        set_slice(1, 30'h2A);
        step(1'b1, 4'b0010, 1'b1, 1'b0);
        set_slice(1, 30'h11);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'b1111, 1'b0, 1'b0);
            chk("bp gnt", 64'(s_gnt[1]), 64'd0);
            chk("bp out", 64'(s_out[1]), 64'h2A);
        end
        step(1'b1, 4'b1111, 1'b1, 1'b0); chk("bp release", 64'(s_gnt[1]), 64'b0100);

        // Sparse requests across the wrap: ch2 just granted, then 0101 -> ch0, ch2.
        step(1'b1, 4'b0101, 1'b1, 1'b0); chk("wrap ch0", 64'(s_gnt[1]), 64'b0001);
        step(1'b1, 4'b0101, 1'b1, 1'b0); chk("wrap ch2", 64'(s_gnt[1]), 64'b0100);

        // OR-mode collision and clear.
        set_slice(0, 30'h0F0);
        set_slice(1, 30'h00F);
        step(1'b1, 4'b0011, 1'b1, 1'b0);
        step(1'b1, 4'b0001, 1'b1, 1'b1);
        chk("or word", 64'(s_out[0]), 64'h0FF);
        chk("or col set", 64'(s_col[0]), 64'd1);
        step(1'b1, 4'b0000, 1'b1, 1'b0);
        chk("or col clr", 64'(s_col[0]), 64'd0);

        // Reset while a word is stalled.
        step(1'b1, 4'b0010, 1'b1, 1'b0);
        step(1'b1, 4'b1111, 1'b0, 1'b0);
        step(1'b0, 4'b1111, 1'b0, 1'b0);
        step(1'b1, 4'b1111, 1'b1, 1'b0);
        chk("mid rst vld", 64'(s_vld[1]), 64'd0);
        chk("mid rst out", 64'(s_out[1]), 64'd0);
        chk("mid rst gnt", 64'(s_gnt[1]), 64'b0001);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < N; c++) set_slice(c, W'($urandom));
            step(($urandom_range(0, 99) >= 2) ? 1'b1 : 1'b0,
                 N'($urandom),
                 ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
        end

        // Drain and confirm nothing is left outstanding.
        for (int i = 0; i < 4; i++) step(1'b1, 4'b0000, 1'b1, 1'b0);
        chk("or drained", 64'(q_or.size()), 64'd0);
        chk("rr drained", 64'(q_rr.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
